// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the hazard / forwarding controller.
//   fwd_sel_e  : EX operand mux select codes (regfile, WB data, EX/MEM ALU result)
//   tag_ctrl_t : control fields of one in-flight instruction tag; the destination
//                register travels beside it because its width is a module parameter.
//   TAG_*      : index of each pipeline tag stage in the tag arrays.
package hazard_fwd_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
  } tag_ctrl_t;

  localparam tag_ctrl_t TAG_EMPTY = '0;

  localparam int NUM_TAG_STAGES = 3;
  localparam int TAG_EX  = 0;
  localparam int TAG_MEM = 1;
  localparam int TAG_WB  = 2;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Bus between the pipeline datapath and the hazard / forwarding controller.
//   master : datapath side, drives the ID-stage instruction fields and flush,
//            receives the forward selects, stall, bubble and stall counter.
//   slave  : controller side.
interface hazard_fwd_ctrl_if #(
  parameter int REG_DIR_WIDTH = 3,
  parameter int CNT_WIDTH     = 16
);
  logic                     id_valid;
  logic [REG_DIR_WIDTH-1:0] id_rs;
  logic [REG_DIR_WIDTH-1:0] id_rt;
  logic [REG_DIR_WIDTH-1:0] id_dest;
  logic                     id_regwrite;
  logic                     id_memread;
  logic                     flush;
  logic [1:0]               Forward_A;
  logic [1:0]               Forward_B;
  logic                     stall;
  logic                     bubble;
  logic [CNT_WIDTH-1:0]     stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memread, flush,
    input  Forward_A, Forward_B, stall, bubble, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memread, flush,
    output Forward_A, Forward_B, stall, bubble, stall_count
  );
endinterface

// File: rtl/hazard_tag_stage.sv
// One stage of the instruction tag pipeline.
//   clk, rst       : clock, asynchronous active-high reset (clears the tag)
//   kill           : load an empty tag instead of d_ctrl (bubble insertion)
//   d_ctrl, d_dest : incoming tag
//   q_ctrl, q_dest : registered tag
module hazard_tag_stage
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int DEST_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kill,
  input  tag_ctrl_t             d_ctrl,
  input  logic [DEST_WIDTH-1:0] d_dest,
  output tag_ctrl_t             q_ctrl,
  output logic [DEST_WIDTH-1:0] q_dest
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_ctrl <= TAG_EMPTY;
      q_dest <= '0;
    end else begin
      q_ctrl <= kill ? TAG_EMPTY : d_ctrl;
      q_dest <= d_dest;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand forwarding control for a 5-stage pipeline.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of hazard_fwd_ctrl_if
//              in : id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memread, flush
//              out: Forward_A/B (registered, valid in the EX cycle), stall and
//                   bubble (combinational), stall_count (saturating)
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_DIR_WIDTH = 3,
  parameter int CNT_WIDTH     = 16,
  parameter int FLUSH_CYCLES  = 1
) (
  input logic               clk,
  input logic               rst,
  hazard_fwd_ctrl_if.slave  bus
);

  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

  tag_ctrl_t                tag_ctrl [NUM_TAG_STAGES];
  logic [REG_DIR_WIDTH-1:0] tag_dest [NUM_TAG_STAGES];
  tag_ctrl_t                id_ctrl;

  logic [FCNT_W-1:0]    fcnt_reg;
  logic [CNT_WIDTH-1:0] stall_count_reg;
  fwd_sel_e             fwd_a_reg, fwd_b_reg;
  fwd_sel_e             fwd_a_next, fwd_b_next;
  logic                 flush_active, load_hazard, stall, bubble;

  function automatic logic tag_writes(input tag_ctrl_t c,
                                      input logic [REG_DIR_WIDTH-1:0] d,
                                      input logic [REG_DIR_WIDTH-1:0] r);
    return c.valid && c.regwrite && (d == r) && (r != '0);
  endfunction

  // The EX producer is younger than the MEM producer, so it is checked first.
  // No WB case: the register file writes through in the same cycle.
  function automatic fwd_sel_e select_for(input logic [REG_DIR_WIDTH-1:0] r,
                                          input tag_ctrl_t ex_c,
                                          input logic [REG_DIR_WIDTH-1:0] ex_d,
                                          input tag_ctrl_t mem_c,
                                          input logic [REG_DIR_WIDTH-1:0] mem_d);
    if (tag_writes(ex_c, ex_d, r))        return FWD_MEM;
    else if (tag_writes(mem_c, mem_d, r)) return FWD_WB;
    else                                  return FWD_REG;
  endfunction

  assign id_ctrl = '{valid: bus.id_valid, regwrite: bus.id_regwrite, memread: bus.id_memread};

  // Tag pipeline: stage 0 is fed from ID (killed on bubble), later stages shift.
  for (genvar gi = 0; gi < NUM_TAG_STAGES; gi++) begin : g_tag
    tag_ctrl_t                d_ctrl;
    logic [REG_DIR_WIDTH-1:0] d_dest;
    logic                     kill;
    if (gi == 0) begin : g_from_id
      assign d_ctrl = id_ctrl;
      assign d_dest = bus.id_dest;
      assign kill   = bubble;
    end else begin : g_shift
      assign d_ctrl = tag_ctrl[gi-1];
      assign d_dest = tag_dest[gi-1];
      assign kill   = 1'b0;
    end
    hazard_tag_stage #(.DEST_WIDTH(REG_DIR_WIDTH)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .kill   (kill),
      .d_ctrl (d_ctrl),
      .d_dest (d_dest),
      .q_ctrl (tag_ctrl[gi]),
      .q_dest (tag_dest[gi])
    );
  end

  // The WB tag only completes the pipeline picture; nothing forwards from it.
  logic wb_tag_unused;
  assign wb_tag_unused = ^{tag_ctrl[TAG_WB], tag_dest[TAG_WB]};

  always_comb begin
    flush_active = bus.flush || (fcnt_reg != '0);
    load_hazard  = tag_ctrl[TAG_EX].memread &&
                   (tag_writes(tag_ctrl[TAG_EX], tag_dest[TAG_EX], bus.id_rs) ||
                    tag_writes(tag_ctrl[TAG_EX], tag_dest[TAG_EX], bus.id_rt));
    // A flush kills the ID instruction, so a hazard behind it is moot.
    stall  = bus.id_valid && !flush_active && load_hazard;
    bubble = stall || flush_active || !bus.id_valid;

    fwd_a_next = FWD_REG;
    fwd_b_next = FWD_REG;
    if (!bubble) begin
      fwd_a_next = select_for(bus.id_rs, tag_ctrl[TAG_EX], tag_dest[TAG_EX],
                              tag_ctrl[TAG_MEM], tag_dest[TAG_MEM]);
      fwd_b_next = select_for(bus.id_rt, tag_ctrl[TAG_EX], tag_dest[TAG_EX],
                              tag_ctrl[TAG_MEM], tag_dest[TAG_MEM]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_reg       <= FWD_REG;
      fwd_b_reg       <= FWD_REG;
      fcnt_reg        <= '0;
      stall_count_reg <= '0;
    end else begin
      fwd_a_reg <= fwd_a_next;
      fwd_b_reg <= fwd_b_next;
      // The flush cycle itself is one killed slot; the counter covers the rest.
      if (bus.flush)             fcnt_reg <= FCNT_RELOAD;
      else if (fcnt_reg != '0)   fcnt_reg <= fcnt_reg - 1'b1;
      if (stall && (stall_count_reg != '1))
        stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign bus.Forward_A   = fwd_a_reg;
  assign bus.Forward_B   = fwd_b_reg;
  assign bus.stall       = stall;
  assign bus.bubble      = bubble;
  assign bus.stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl (FLUSH_CYCLES = 2).
module tb_hazard_fwd_ctrl;

  logic clk;
  logic rst;

  hazard_fwd_ctrl_if #(.REG_DIR_WIDTH(3), .CNT_WIDTH(16)) bus ();

  hazard_fwd_ctrl #(.REG_DIR_WIDTH(3), .CNT_WIDTH(16), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] rs, rt, dest;
    logic       rw, mr, fl;
    logic       es, eb;
    logic [1:0] fa, fb;
  } step_t;

  typedef struct {
    logic       s, b;
    logic [1:0] fa, fb;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_cnt  = 0;

  function automatic step_t mk(logic v, logic [2:0] rs, logic [2:0] rt, logic [2:0] dest,
                               logic rw, logic mr, logic fl, logic es, logic eb,
                               logic [1:0] fa, logic [1:0] fb);
    step_t s;
    s.v = v; s.rs = rs; s.rt = rt; s.dest = dest; s.rw = rw; s.mr = mr; s.fl = fl;
    s.es = es; s.eb = eb; s.fa = fa; s.fb = fb;
    return s;
  endfunction

  function automatic step_t nop();
    return mk(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
  endfunction

  // Drives one ID slot, samples the combinational outputs mid-cycle, pushes the
  // expectation to the scoreboard, and returns 1 time unit after the next edge.
  task automatic apply_step(input step_t s, output logic obs_s, output logic obs_b);
    exp_t e;
    bus.id_valid = s.v; bus.id_rs = s.rs; bus.id_rt = s.rt; bus.id_dest = s.dest;
    bus.id_regwrite = s.rw; bus.id_memread = s.mr; bus.flush = s.fl;
    e.s = s.es; e.b = s.eb; e.fa = s.fa; e.fb = s.fb;
    sb.push_back(e);
    if (s.es) exp_cnt++;
    @(negedge clk);
    obs_s = bus.stall;
    obs_b = bus.bubble;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_dest = '0;
    bus.id_regwrite = 1'b0; bus.id_memread = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (bus.Forward_A !== 2'd0) begin failures++; $display("FAIL reset_fwd_a got=%0d want=0", bus.Forward_A); end
    if (bus.Forward_B !== 2'd0) begin failures++; $display("FAIL reset_fwd_b got=%0d want=0", bus.Forward_B); end
    if (bus.stall_count !== 16'd0) begin failures++; $display("FAIL reset_stall_count got=%0d want=0", bus.stall_count); end
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b want=0", bus.stall); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    exp_t  e;
    logic  os, ob;
    st.push_back(mk(1, 3'd1, 3'd2, 3'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0)); // add r3
    st.push_back(mk(1, 3'd3, 3'd4, 3'd6, 1, 0, 0, 0, 0, 2'd2, 2'd0)); // sub rs=3
    st.push_back(nop());
    st.push_back(nop());
    foreach (st[i]) begin
      apply_step(st[i], os, ob);
      e = sb.pop_front();
      checks += 4;
      if (os !== e.s) begin failures++; $display("FAIL b2b_stall step=%0d got=%0b want=%0b", i, os, e.s); end
      if (ob !== e.b) begin failures++; $display("FAIL b2b_bubble step=%0d got=%0b want=%0b", i, ob, e.b); end
      if (bus.Forward_A !== e.fa) begin failures++; $display("FAIL b2b_fwd_a step=%0d got=%0d want=%0d", i, bus.Forward_A, e.fa); end
      if (bus.Forward_B !== e.fb) begin failures++; $display("FAIL b2b_fwd_b step=%0d got=%0d want=%0d", i, bus.Forward_B, e.fb); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_distance();
    step_t st[$];
    exp_t  e;
    logic  os, ob;
    st.push_back(mk(1, 3'd1, 3'd2, 3'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0)); // add r3
    st.push_back(nop());
    st.push_back(mk(1, 3'd1, 3'd3, 3'd4, 1, 0, 0, 0, 0, 2'd0, 2'd1)); // or rt=3, distance 2
    st.push_back(nop());
    st.push_back(nop());
    st.push_back(mk(1, 3'd1, 3'd2, 3'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0)); // add r3
    st.push_back(nop());
    st.push_back(nop());
    st.push_back(mk(1, 3'd1, 3'd3, 3'd4, 1, 0, 0, 0, 0, 2'd0, 2'd0)); // distance 3: regfile
    st.push_back(nop());
    st.push_back(nop());
    foreach (st[i]) begin
      apply_step(st[i], os, ob);
      e = sb.pop_front();
      checks += 4;
      if (os !== e.s) begin failures++; $display("FAIL dist_stall step=%0d got=%0b want=%0b", i, os, e.s); end
      if (ob !== e.b) begin failures++; $display("FAIL dist_bubble step=%0d got=%0b want=%0b", i, ob, e.b); end
      if (bus.Forward_A !== e.fa) begin failures++; $display("FAIL dist_fwd_a step=%0d got=%0d want=%0d", i, bus.Forward_A, e.fa); end
      if (bus.Forward_B !== e.fb) begin failures++; $display("FAIL dist_fwd_b step=%0d got=%0d want=%0d", i, bus.Forward_B, e.fb); end
    end
    $display("test_distance done");
  endtask

  task automatic test_load_use();
    step_t st[$];
    exp_t  e;
    logic  os, ob;
    st.push_back(mk(1, 3'd1, 3'd0, 3'd5, 1, 1, 0, 0, 0, 2'd0, 2'd0)); // lw r5
    st.push_back(mk(1, 3'd5, 3'd2, 3'd7, 1, 0, 0, 1, 1, 2'd0, 2'd0)); // add rs=5: stall
    st.push_back(mk(1, 3'd5, 3'd2, 3'd7, 1, 0, 0, 0, 0, 2'd1, 2'd0)); // retry: from WB data
    st.push_back(nop());
    st.push_back(nop());
    foreach (st[i]) begin
      apply_step(st[i], os, ob);
      e = sb.pop_front();
      checks += 4;
      if (os !== e.s) begin failures++; $display("FAIL lu_stall step=%0d got=%0b want=%0b", i, os, e.s); end
      if (ob !== e.b) begin failures++; $display("FAIL lu_bubble step=%0d got=%0b want=%0b", i, ob, e.b); end
      if (bus.Forward_A !== e.fa) begin failures++; $display("FAIL lu_fwd_a step=%0d got=%0d want=%0d", i, bus.Forward_A, e.fa); end
      if (bus.Forward_B !== e.fb) begin failures++; $display("FAIL lu_fwd_b step=%0d got=%0d want=%0d", i, bus.Forward_B, e.fb); end
    end
    checks++;
    if (bus.stall_count !== 16'(exp_cnt)) begin failures++; $display("FAIL lu_stall_count got=%0d want=%0d", bus.stall_count, exp_cnt); end
    $display("test_load_use done");
  endtask

  task automatic test_r0_double();
    step_t st[$];
    exp_t  e;
    logic  os, ob;
    st.push_back(mk(1, 3'd1, 3'd2, 3'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0)); // add r0
    st.push_back(mk(1, 3'd0, 3'd0, 3'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0)); // use r0
    st.push_back(mk(1, 3'd1, 3'd1, 3'd0, 1, 1, 0, 0, 0, 2'd0, 2'd0)); // lw r0
    st.push_back(mk(1, 3'd0, 3'd0, 3'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0)); // use r0: no stall
    st.push_back(nop());
    st.push_back(nop());
    st.push_back(mk(1, 3'd1, 3'd2, 3'd4, 1, 0, 0, 0, 0, 2'd0, 2'd0)); // add r4
    st.push_back(mk(1, 3'd1, 3'd2, 3'd4, 1, 0, 0, 0, 0, 2'd0, 2'd0)); // add r4
    st.push_back(mk(1, 3'd4, 3'd4, 3'd5, 1, 0, 0, 0, 0, 2'd2, 2'd2)); // youngest wins
    st.push_back(mk(1, 3'd4, 3'd5, 3'd0, 0, 0, 0, 0, 0, 2'd1, 2'd2)); // mixed sources
    st.push_back(nop());
    st.push_back(nop());
    foreach (st[i]) begin
      apply_step(st[i], os, ob);
      e = sb.pop_front();
      checks += 4;
      if (os !== e.s) begin failures++; $display("FAIL r0dbl_stall step=%0d got=%0b want=%0b", i, os, e.s); end
      if (ob !== e.b) begin failures++; $display("FAIL r0dbl_bubble step=%0d got=%0b want=%0b", i, ob, e.b); end
      if (bus.Forward_A !== e.fa) begin failures++; $display("FAIL r0dbl_fwd_a step=%0d got=%0d want=%0d", i, bus.Forward_A, e.fa); end
      if (bus.Forward_B !== e.fb) begin failures++; $display("FAIL r0dbl_fwd_b step=%0d got=%0d want=%0d", i, bus.Forward_B, e.fb); end
    end
    $display("test_r0_double done");
  endtask

  task automatic test_flush();
    step_t st[$];
    exp_t  e;
    logic  os, ob;
    st.push_back(mk(1, 3'd1, 3'd0, 3'd5, 1, 1, 0, 0, 0, 2'd0, 2'd0)); // lw r5
    st.push_back(mk(1, 3'd5, 3'd0, 3'd7, 1, 0, 1, 0, 1, 2'd0, 2'd0)); // flush beats load-use
    st.push_back(mk(1, 3'd5, 3'd0, 3'd7, 1, 0, 0, 0, 1, 2'd0, 2'd0)); // second killed slot
    st.push_back(mk(1, 3'd7, 3'd5, 3'd6, 1, 0, 0, 0, 0, 2'd0, 2'd0)); // killed r7 not forwarded
    st.push_back(mk(1, 3'd6, 3'd0, 3'd2, 1, 0, 1, 0, 1, 2'd0, 2'd0)); // flush
    st.push_back(mk(1, 3'd0, 3'd0, 3'd2, 1, 0, 1, 0, 1, 2'd0, 2'd0)); // flush again: reload
    st.push_back(mk(1, 3'd0, 3'd0, 3'd2, 1, 0, 0, 0, 1, 2'd0, 2'd0)); // still killed
    st.push_back(mk(1, 3'd2, 3'd2, 3'd1, 1, 0, 0, 0, 0, 2'd0, 2'd0)); // window closed
    st.push_back(nop());
    st.push_back(nop());
    foreach (st[i]) begin
      apply_step(st[i], os, ob);
      e = sb.pop_front();
      checks += 4;
      if (os !== e.s) begin failures++; $display("FAIL flush_stall step=%0d got=%0b want=%0b", i, os, e.s); end
      if (ob !== e.b) begin failures++; $display("FAIL flush_bubble step=%0d got=%0b want=%0b", i, ob, e.b); end
      if (bus.Forward_A !== e.fa) begin failures++; $display("FAIL flush_fwd_a step=%0d got=%0d want=%0d", i, bus.Forward_A, e.fa); end
      if (bus.Forward_B !== e.fb) begin failures++; $display("FAIL flush_fwd_b step=%0d got=%0d want=%0d", i, bus.Forward_B, e.fb); end
    end
    checks++;
    if (bus.stall_count !== 16'(exp_cnt)) begin failures++; $display("FAIL flush_stall_count got=%0d want=%0d", bus.stall_count, exp_cnt); end
    $display("test_flush done");
  endtask

  task automatic test_reset_mid_stall();
    step_t st[$];
    exp_t  e;
    logic  os, ob;
    st.push_back(mk(1, 3'd1, 3'd1, 3'd2, 1, 0, 0, 0, 0, 2'd0, 2'd0)); // add r2
    st.push_back(mk(1, 3'd2, 3'd0, 3'd5, 1, 1, 0, 0, 0, 2'd2, 2'd0)); // lw r5 uses r2
    foreach (st[i]) begin
      apply_step(st[i], os, ob);
      e = sb.pop_front();
      checks += 2;
      if (os !== e.s) begin failures++; $display("FAIL rms_pre_stall step=%0d got=%0b want=%0b", i, os, e.s); end
      if (bus.Forward_A !== e.fa) begin failures++; $display("FAIL rms_pre_fwd_a step=%0d got=%0d want=%0d", i, bus.Forward_A, e.fa); end
    end
    // Dependent add sits in ID while the load is in EX.
    bus.id_valid = 1'b1; bus.id_rs = 3'd5; bus.id_rt = 3'd0; bus.id_dest = 3'd7;
    bus.id_regwrite = 1'b1; bus.id_memread = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1) begin failures++; $display("FAIL rms_stall_before_rst got=%0b want=1", bus.stall); end
    #1 rst = 1'b1;
    #1;
    exp_cnt = 0;
    checks += 4;
    if (bus.Forward_A !== 2'd0) begin failures++; $display("FAIL rms_fwd_a got=%0d want=0", bus.Forward_A); end
    if (bus.Forward_B !== 2'd0) begin failures++; $display("FAIL rms_fwd_b got=%0d want=0", bus.Forward_B); end
    if (bus.stall_count !== 16'd0) begin failures++; $display("FAIL rms_stall_count got=%0d want=0", bus.stall_count); end
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL rms_stall_in_rst got=%0b want=0", bus.stall); end
    bus.id_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    st.delete();
    st.push_back(mk(1, 3'd1, 3'd2, 3'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0)); // add r3
    st.push_back(mk(1, 3'd3, 3'd4, 3'd6, 1, 0, 0, 0, 0, 2'd2, 2'd0)); // sub rs=3
    st.push_back(nop());
    foreach (st[i]) begin
      apply_step(st[i], os, ob);
      e = sb.pop_front();
      checks += 4;
      if (os !== e.s) begin failures++; $display("FAIL rms_post_stall step=%0d got=%0b want=%0b", i, os, e.s); end
      if (ob !== e.b) begin failures++; $display("FAIL rms_post_bubble step=%0d got=%0b want=%0b", i, ob, e.b); end
      if (bus.Forward_A !== e.fa) begin failures++; $display("FAIL rms_post_fwd_a step=%0d got=%0d want=%0d", i, bus.Forward_A, e.fa); end
      if (bus.Forward_B !== e.fb) begin failures++; $display("FAIL rms_post_fwd_b step=%0d got=%0d want=%0d", i, bus.Forward_B, e.fb); end
    end
    checks++;
    if (bus.stall_count !== 16'(exp_cnt)) begin failures++; $display("FAIL rms_post_stall_count got=%0d want=%0d", bus.stall_count, exp_cnt); end
    $display("test_reset_mid_stall done");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_r0_double();
    test_flush();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Produces the Forward_A/Forward_B selects consumed by the EX-stage operand muxes, plus the load-use stall and flush bubbles that feed them.
- Keeps an internal tag pipeline (EX, MEM, WB) holding each in-flight instruction's destination register, RegWrite and MemRead.
- Compares the ID-stage sources against these tags and registers the select codes on the ID->EX edge, so they are valid during the instruction's EX cycle.

Parameters:
- REG_DIR_WIDTH, 3, register address width.
- CNT_WIDTH, 16, stall counter width.
- FLUSH_CYCLES, 1, number of ID-stage slots killed per flush pulse (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_DIR_WIDTH  ID source register A.
- id_rt  input  REG_DIR_WIDTH  ID source register B.
- id_dest  input  REG_DIR_WIDTH  ID destination, already resolved from RegDst.
- id_regwrite  input  1  ID instruction writes the register file.
- id_memread  input  1  ID instruction is a load.
- flush  input  1  branch/jump taken, one-cycle pulse.
- Forward_A  output  2  EX operand A select: 0 regfile, 1 WBData, 2 Address (EX/MEM ALU result).
- Forward_B  output  2  EX operand B select, same encoding.
- stall  output  1  hold PC and IF/ID; combinational.
- bubble  output  1  ID/EX register loads a NOP this edge; combinational.
- stall_count  output  CNT_WIDTH  saturating count of stall cycles.

Behaviour:
- Reset (async): all tag valids 0, Forward_A/B = 0, stall_count = 0, flush counter = 0. Reset asserted mid-stall or mid-flush abandons it; the first cycle after release starts clean.
- Tag: {valid, regwrite, memread, dest}. A tag "writes r" when valid & regwrite & dest == r & r != 0.
- Tag shift, every edge: wb <= mem; mem <= ex; ex <= bubble ? invalid : ID tag.
- flush_active = flush | (fcnt != 0).
  - On flush: fcnt <= FLUSH_CYCLES-1.
  - Otherwise fcnt decrements to 0.
  - A new flush while counting reloads the counter.
- stall = id_valid & ~flush_active & ex tag writes r & ex.memread, for r = id_rs or id_rt.
- bubble = stall | flush_active | ~id_valid.
- Forward next-value, per source r (rs -> A, rt -> B):
  - 2 if the ex tag writes r (that producer will be in MEM).
  - Else 1 if the mem tag writes r (it will be in WB).
  - Else 0.
  - The ex tag has priority (youngest producer wins).
  - The wb tag is not forwarded: the register file is write-through for the same cycle.
  - r == 0 always gives 0.
- Forward_A/B are registered on every edge. When bubble = 1, both load 0.
- Latency: select visible exactly one cycle after the instruction sits in ID, i.e. during its EX cycle.
- Load-use: the stall lasts one cycle. On the next cycle the load has moved to MEM, and the retried ID instruction gets Forward = 1 when it enters EX.
- Simultaneous flush and hazard: flush wins; stall = 0 and the instruction is killed.
- stall_count increments each cycle stall = 1 and saturates at all-ones.
- No other outputs or state.

Decomposition:
- Shared package: forward select constants FWD_REG=0, FWD_WB=1, FWD_MEM=2; the tag record field layout.
- One sub-module, hazard_tag_stage: a single tag register with valid clear. It is instantiated three times for EX, MEM and WB.
- Compare and select logic stays in the top module.

Test Plan:
- Back-to-back ALU dependency: add r3 (id_dest=3, regwrite) then sub with rs=3 -> Forward_A=2 during sub's EX cycle, stall=0.
- Distance 2: add r3, nop, or with rt=3 -> Forward_B=1 in or's EX. Distance 3 -> Forward_B=0.
- Load-use: lw r5 (memread) then add rs=5 -> stall=1 for exactly one cycle, bubble=1, stall_count=1; retried add gets Forward_A=1.
- r0 and double producer:
  - add r0 then use rs=0 -> Forward_A=0.
  - add r4; add r4; use r4 -> Forward=2 (youngest producer).
- Flush with FLUSH_CYCLES=2:
  - flush pulse -> bubble=1 for 2 cycles.
  - A load-use hazard inside the window gives stall=0, and killed instructions never forward.
- Reset mid-stall: assert rst during stall -> Forward_A/B=0, stall_count=0, tags cleared; the next dependent pair behaves as in the first scenario.
